// File: rtl/tlm_result_collector.sv
`default_nettype none
// ============================================================================
// Module      : tlm_result_collector
// Description : Packs NUM result items into a flat batch and publishes it
//               over a valid/ready handshake, counting items lost while full.
// Revision    : 1.0 - initial release
// ============================================================================
module tlm_result_collector #(
    parameter  int NUM        = 1000,
    parameter  int ITEM_WIDTH = 8,
    localparam int CNT_W      = $clog2(NUM + 1)
) (
    input  logic                      clk_i,
    input  logic                      reset_i,
    input  logic [ITEM_WIDTH-1:0]     res_i,
    input  logic                      res_valid_i,
    input  logic                      flush_i,
    output logic [NUM*ITEM_WIDTH-1:0] batch_o,
    output logic [CNT_W-1:0]          batch_cnt_o,
    output logic [15:0]               batch_sum_o,
    output logic                      batch_valid_o,
    input  logic                      batch_ready_i,
    output logic                      overflow_o,
    output logic [15:0]               drop_cnt_o
);

    localparam logic [0:0]       c_ST_COLLECT = 1'b0;
    localparam logic [0:0]       c_ST_FULL    = 1'b1;
    localparam logic [CNT_W-1:0] c_NUM_CNT    = CNT_W'(NUM);
    localparam logic [15:0]      c_DROP_MAX   = 16'hFFFF;

    logic [0:0]                state_q, state_d;
    logic [CNT_W-1:0]          wr_idx_q, wr_idx_d;
    logic [15:0]               sum_q, sum_d;
    logic [NUM*ITEM_WIDTH-1:0] batch_q, batch_d;
    logic [CNT_W-1:0]          batch_cnt_q, batch_cnt_d;
    logic [15:0]               batch_sum_q, batch_sum_d;
    logic                      batch_valid_q, batch_valid_d;
    logic                      overflow_q, overflow_d;
    logic [15:0]               drop_cnt_q, drop_cnt_d;

    logic [15:0]      w_item16;
    logic             w_in_full;
    logic             w_accept;
    logic             w_publish;
    logic [CNT_W-1:0] w_base_idx;
    logic [CNT_W-1:0] w_cnt_after;
    logic [15:0]      w_base_sum;
    logic [15:0]      w_sum_after;

    generate
        if (ITEM_WIDTH >= 16) begin : g_item_wide
            assign w_item16 = res_i[15:0];
        end else begin : g_item_narrow
            assign w_item16 = {{(16-ITEM_WIDTH){1'b0}}, res_i};
        end
    endgenerate

    always_comb begin
        w_in_full   = (state_q == c_ST_FULL);
        // An item arriving on the handshake cycle opens the next batch at slot 0.
        w_accept    = res_valid_i && (!w_in_full || batch_ready_i);
        w_base_idx  = w_in_full ? '0 : wr_idx_q;
        w_base_sum  = w_in_full ? 16'd0 : sum_q;
        w_cnt_after = w_base_idx + (w_accept ? CNT_W'(1) : CNT_W'(0));
        w_sum_after = w_base_sum + (w_accept ? w_item16 : 16'd0);
        w_publish   = (w_cnt_after == c_NUM_CNT) ||
                      (!w_in_full && flush_i && (w_cnt_after != '0));

        state_d       = state_q;
        wr_idx_d      = wr_idx_q;
        sum_d         = sum_q;
        batch_d       = batch_q;
        batch_cnt_d   = batch_cnt_q;
        batch_sum_d   = batch_sum_q;
        batch_valid_d = batch_valid_q;
        overflow_d    = overflow_q;
        drop_cnt_d    = drop_cnt_q;

        if (w_accept) begin
            batch_d[w_base_idx*ITEM_WIDTH +: ITEM_WIDTH] = res_i;
        end

        if (w_in_full && !batch_ready_i) begin
            if (res_valid_i) begin
                overflow_d = 1'b1;
                if (drop_cnt_q != c_DROP_MAX) begin
                    drop_cnt_d = drop_cnt_q + 16'd1;
                end
            end
        end else if (w_publish) begin
            state_d       = c_ST_FULL;
            batch_valid_d = 1'b1;
            batch_cnt_d   = w_cnt_after;
            batch_sum_d   = w_sum_after;
            wr_idx_d      = '0;
            sum_d         = 16'd0;
        end else begin
            state_d       = c_ST_COLLECT;
            batch_valid_d = 1'b0;
            wr_idx_d      = w_cnt_after;
            sum_d         = w_sum_after;
        end
    end

    always_ff @(posedge clk_i) begin
        batch_q <= batch_d;
        if (!reset_i) begin
            state_q       <= c_ST_COLLECT;
            wr_idx_q      <= '0;
            sum_q         <= 16'd0;
            batch_cnt_q   <= '0;
            batch_sum_q   <= 16'd0;
            batch_valid_q <= 1'b0;
            overflow_q    <= 1'b0;
            drop_cnt_q    <= 16'd0;
        end else begin
            state_q       <= state_d;
            wr_idx_q      <= wr_idx_d;
            sum_q         <= sum_d;
            batch_cnt_q   <= batch_cnt_d;
            batch_sum_q   <= batch_sum_d;
            batch_valid_q <= batch_valid_d;
            overflow_q    <= overflow_d;
            drop_cnt_q    <= drop_cnt_d;
        end
    end

    assign batch_o       = batch_q;
    assign batch_cnt_o   = batch_cnt_q;
    assign batch_sum_o   = batch_sum_q;
    assign batch_valid_o = batch_valid_q;
    assign overflow_o    = overflow_q;
    assign drop_cnt_o    = drop_cnt_q;

endmodule
`default_nettype wire

// File: tb/tb_tlm_result_collector.sv
`default_nettype none
// ============================================================================
// Module      : tb_tlm_result_collector
// Description : Self-checking bench; queue-based batch model plus a NUM=1000
//               streaming instance.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_tlm_result_collector;

    localparam int NUM  = 4;
    localparam int BNUM = 1000;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst_n;
    logic [7:0]  res;
    logic        res_v, flush, ready;
    logic [31:0] batch;
    logic [2:0]  cnt;
    logic [15:0] sum, drop;
    logic        valid, ovf;

    logic [7:0]        b_res;
    logic              b_v, b_flush, b_ready;
    logic [BNUM*8-1:0] b_batch;
    logic [9:0]        b_cnt;
    logic [15:0]       b_sum, b_drop;
    logic              b_valid, b_ovf;

    tlm_result_collector #(.NUM(NUM), .ITEM_WIDTH(8)) u_dut (
        .clk_i(clk), .reset_i(rst_n), .res_i(res), .res_valid_i(res_v),
        .flush_i(flush), .batch_o(batch), .batch_cnt_o(cnt), .batch_sum_o(sum),
        .batch_valid_o(valid), .batch_ready_i(ready), .overflow_o(ovf),
        .drop_cnt_o(drop)
    );

    tlm_result_collector #(.NUM(BNUM), .ITEM_WIDTH(8)) u_big (
        .clk_i(clk), .reset_i(rst_n), .res_i(b_res), .res_valid_i(b_v),
        .flush_i(b_flush), .batch_o(b_batch), .batch_cnt_o(b_cnt),
        .batch_sum_o(b_sum), .batch_valid_o(b_valid), .batch_ready_i(b_ready),
        .overflow_o(b_ovf), .drop_cnt_o(b_drop)
    );

    int vectors = 0;
    int errors  = 0;

    // Reference model: pending items, the last published batch and status.
    logic [7:0] mq[$];
    logic [7:0] m_batch[$];
    bit         m_full = 1'b0;
    int         m_cnt  = 0;
    int         m_sum  = 0;
    bit         m_ovf  = 1'b0;
    int         m_drop = 0;

    task automatic model_publish();
        int s = 0;
        foreach (mq[i]) s += int'(mq[i]);
        m_batch = mq;
        m_cnt   = mq.size();
        m_sum   = s % 65536;
        m_full  = 1'b1;
        mq.delete();
    endtask

    task automatic drive(input bit r, input bit v, input logic [7:0] d,
                         input bit f, input bit rd);
        @(negedge clk);
        rst_n = r; res_v = v; res = d; flush = f; ready = rd;
        @(posedge clk);
        if (!r) begin
            mq.delete(); m_full = 1'b0; m_cnt = 0; m_sum = 0; m_ovf = 1'b0; m_drop = 0;
        end else if (!m_full) begin
            if (v) mq.push_back(d);
            if (mq.size() == NUM || (f && mq.size() > 0)) model_publish();
        end else if (rd) begin
            m_full = 1'b0;
            if (v) mq.push_back(d);
            if (mq.size() == NUM) model_publish();
        end else if (v) begin
            m_ovf = 1'b1;
            if (m_drop < 65535) m_drop++;
        end
        #1;
    endtask

    task automatic test_reset();
        drive(0, 0, 8'h00, 0, 0);
        drive(0, 1, 8'h55, 1, 1);
        vectors++; if (valid !== 1'b0) begin errors++; $display("FAIL reset_valid: got %0b expected 0", valid); end
        vectors++; if (cnt !== 3'd0) begin errors++; $display("FAIL reset_cnt: got %0d expected 0", cnt); end
        vectors++; if (sum !== 16'd0) begin errors++; $display("FAIL reset_sum: got %0h expected 0", sum); end
        vectors++; if (ovf !== 1'b0 || drop !== 16'd0) begin errors++; $display("FAIL reset_status: got ovf=%0b drop=%0d expected 0/0", ovf, drop); end
        vectors++; if (b_valid !== 1'b0 || b_cnt !== 10'd0 || b_drop !== 16'd0) begin errors++; $display("FAIL reset_big: got valid=%0b cnt=%0d drop=%0d expected 0", b_valid, b_cnt, b_drop); end
    endtask

    task automatic test_full_batch();
        drive(1, 1, 8'd1, 0, 1);
        drive(1, 1, 8'd2, 0, 1);
        drive(1, 1, 8'd3, 0, 1);
        vectors++; if (valid !== 1'b0) begin errors++; $display("FAIL full_early_valid: got %0b expected 0", valid); end
        drive(1, 1, 8'd4, 0, 1);
        vectors++; if (valid !== 1'b1) begin errors++; $display("FAIL full_valid: got %0b expected 1", valid); end
        vectors++; if (batch !== 32'h04030201) begin errors++; $display("FAIL full_batch: got %h expected 04030201", batch); end
        vectors++; if (cnt !== 3'd4 || sum !== 16'd10) begin errors++; $display("FAIL full_cnt_sum: got %0d/%0d expected 4/10", cnt, sum); end
        drive(1, 0, 8'd0, 0, 1);
        vectors++; if (valid !== 1'b0) begin errors++; $display("FAIL full_release: got %0b expected 0", valid); end
    endtask

    task automatic test_overflow();
        for (int i = 1; i <= 4; i++) drive(1, 1, 8'(i), 0, 0);
        for (int i = 0; i < 3; i++) begin
            drive(1, 1, 8'h09, 1, 0);
            vectors++; if (valid !== 1'b1 || batch !== 32'h04030201 || cnt !== 3'd4) begin errors++; $display("FAIL ovf_hold: got valid=%0b batch=%h cnt=%0d expected 1/04030201/4", valid, batch, cnt); end
        end
        vectors++; if (ovf !== 1'b1) begin errors++; $display("FAIL ovf_flag: got %0b expected 1", ovf); end
        vectors++; if (drop !== 16'd3) begin errors++; $display("FAIL ovf_drops: got %0d expected 3", drop); end
        drive(1, 0, 8'd0, 0, 1);
        vectors++; if (valid !== 1'b0) begin errors++; $display("FAIL ovf_release: got %0b expected 0", valid); end
        drive(1, 1, 8'h11, 0, 0);
        drive(1, 1, 8'h22, 0, 0);
        drive(1, 0, 8'h00, 1, 0);
        vectors++; if (valid !== 1'b1 || cnt !== 3'd2 || sum !== 16'h0033 || batch[15:0] !== 16'h2211) begin errors++; $display("FAIL ovf_next_empty: got valid=%0b cnt=%0d sum=%h lo=%h expected 1/2/0033/2211", valid, cnt, sum, batch[15:0]); end
        drive(1, 0, 8'd0, 0, 1);
    endtask

    task automatic test_flush();
        drive(1, 1, 8'd5, 0, 0);
        drive(1, 1, 8'd6, 0, 0);
        drive(1, 1, 8'd7, 1, 0);
        vectors++; if (valid !== 1'b1 || cnt !== 3'd3 || sum !== 16'd18) begin errors++; $display("FAIL flush_cnt_sum: got valid=%0b cnt=%0d sum=%0d expected 1/3/18", valid, cnt, sum); end
        vectors++; if (batch[23:0] !== 24'h070605) begin errors++; $display("FAIL flush_slots: got %h expected 070605", batch[23:0]); end
        drive(1, 0, 8'd0, 0, 1);
        drive(1, 0, 8'd0, 1, 0);
        vectors++; if (valid !== 1'b0) begin errors++; $display("FAIL flush_empty: got %0b expected 0", valid); end
    endtask

    task automatic test_accept_in_full();
        int drops_before;
        for (int i = 1; i <= 4; i++) drive(1, 1, 8'(i), 0, 0);
        drops_before = m_drop;
        drive(1, 1, 8'h8A, 0, 1);
        vectors++; if (valid !== 1'b0 || drop !== 16'(drops_before)) begin errors++; $display("FAIL accept_no_drop: got valid=%0b drop=%0d expected 0/%0d", valid, drop, drops_before); end
        drive(1, 1, 8'd1, 0, 0);
        drive(1, 1, 8'd2, 0, 0);
        drive(1, 1, 8'd3, 0, 0);
        vectors++; if (valid !== 1'b1 || batch !== 32'h0302018A || cnt !== 3'd4 || sum !== 16'd144) begin errors++; $display("FAIL accept_slot0: got valid=%0b batch=%h cnt=%0d sum=%0d expected 1/0302018a/4/144", valid, batch, cnt, sum); end
        drive(1, 0, 8'd0, 0, 1);
    endtask

    task automatic test_reset_mid();
        drive(1, 1, 8'd1, 0, 0);
        drive(1, 1, 8'd2, 0, 0);
        drive(0, 0, 8'd0, 0, 0);
        vectors++; if (valid !== 1'b0 || cnt !== 3'd0 || sum !== 16'd0 || ovf !== 1'b0 || drop !== 16'd0) begin errors++; $display("FAIL rstmid_status: got valid=%0b cnt=%0d sum=%0d ovf=%0b drop=%0d expected all 0", valid, cnt, sum, ovf, drop); end
        for (int i = 10; i <= 13; i++) drive(1, 1, 8'(i), 0, 0);
        vectors++; if (valid !== 1'b1 || batch !== 32'h0D0C0B0A || cnt !== 3'd4 || sum !== 16'd46) begin errors++; $display("FAIL rstmid_batch: got valid=%0b batch=%h cnt=%0d sum=%0d expected 1/0d0c0b0a/4/46", valid, batch, cnt, sum); end
        drive(1, 0, 8'd0, 0, 1);
    endtask

    task automatic test_random();
        for (int n = 0; n < 500; n++) begin
            bit r, v, f, rd;
            r  = ($urandom_range(0, 99) != 0);
            v  = ($urandom_range(0, 9) < 7);
            f  = ($urandom_range(0, 9) < 2);
            rd = ($urandom_range(0, 9) < 4);
            drive(r, v, 8'($urandom_range(0, 255)), f, rd);
            vectors++; if (valid !== m_full) begin errors++; $display("FAIL rand_valid @%0d: got %0b expected %0b", n, valid, m_full); end
            vectors++; if (ovf !== m_ovf || drop !== 16'(m_drop)) begin errors++; $display("FAIL rand_status @%0d: got ovf=%0b drop=%0d expected %0b/%0d", n, ovf, drop, m_ovf, m_drop); end
            if (m_full) begin
                vectors++; if (cnt !== 3'(m_cnt) || sum !== 16'(m_sum)) begin errors++; $display("FAIL rand_cnt_sum @%0d: got %0d/%0d expected %0d/%0d", n, cnt, sum, m_cnt, m_sum); end
                for (int k = 0; k < m_cnt; k++) begin
                    vectors++; if (batch[k*8 +: 8] !== m_batch[k]) begin errors++; $display("FAIL rand_slot%0d @%0d: got %h expected %h", k, n, batch[k*8 +: 8], m_batch[k]); end
                end
            end
        end
        drive(1, 0, 8'd0, 0, 1);
    endtask

    task automatic test_back_to_back();
        int pubs = 0;
        for (int n = 0; n < 3 * BNUM; n++) begin
            @(negedge clk);
            b_v = 1'b1; b_res = 8'hFF; b_ready = 1'b1; b_flush = 1'b0;
            @(posedge clk);
            #1;
            if (b_valid === 1'b1) begin
                pubs++;
                vectors++; if (b_cnt !== 10'd1000 || b_sum !== 16'd58392) begin errors++; $display("FAIL b2b_cnt_sum: got %0d/%0d expected 1000/58392", b_cnt, b_sum); end
                vectors++; if (b_batch[7:0] !== 8'hFF || b_batch[BNUM*8-1 -: 8] !== 8'hFF) begin errors++; $display("FAIL b2b_slots: got %h/%h expected ff/ff", b_batch[7:0], b_batch[BNUM*8-1 -: 8]); end
            end
        end
        @(negedge clk);
        b_v = 1'b0;
        @(posedge clk);
        #1;
        vectors++; if (pubs != 3) begin errors++; $display("FAIL b2b_batches: got %0d expected 3", pubs); end
        vectors++; if (b_drop !== 16'd0 || b_ovf !== 1'b0) begin errors++; $display("FAIL b2b_drops: got drop=%0d ovf=%0b expected 0/0", b_drop, b_ovf); end
        vectors++; if (b_valid !== 1'b0) begin errors++; $display("FAIL b2b_release: got %0b expected 0", b_valid); end
    endtask

    initial begin
        rst_n = 1'b0; res = 8'd0; res_v = 1'b0; flush = 1'b0; ready = 1'b0;
        b_res = 8'd0; b_v = 1'b0; b_flush = 1'b0; b_ready = 1'b0;
        test_reset();
        test_full_batch();
        test_overflow();
        test_flush();
        test_accept_in_full();
        test_reset_mid();
        test_random();
        test_back_to_back();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

endmodule
`default_nettype wire
